md5_msg_packer: RTL and testbench

//  Byte-serial front end for md5core. Collects a variable-length message (1..MAX_BYTES

---
 rtl/md5_msg_packer.sv | 133 +++++++++++++
 tb/tb_md5_msg_packer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/md5_msg_packer.sv
// ----------------------------------------------------------------------------
// md5_msg_packer
//
// Byte-serial front end for md5core. Collects a message of 1..MAX_BYTES bytes,
// first byte most significant, and packs it into the 448-bit m_in field. The
// field holds the message bytes, then a 0x80 marker byte, then zero fill. The
// module also reports the message length in bits. One block is offered per
// message on a valid/ready handshake.
//
// Ports
//   clk          in   1    system clock, rising edge
//   reset        in   1    synchronous, active-high
//   en           in   1    global enable; 0 freezes all state
//   byte_in      in   8    message byte
//   byte_valid   in   1    byte_in is valid
//   byte_last    in   1    byte_in is the final byte of the message
//   byte_ready   out  1    a byte is accepted this cycle when valid
//   m_out        out  448  padded message field
//   length       out  16   message length in bits
//   block_valid  out  1    m_out/length hold a complete block
//   block_ready  in   1    downstream takes the block
//   overflow     out  1    one-cycle pulse: an over-long message was dropped
// ----------------------------------------------------------------------------
module md5_msg_packer #(
   parameter int MAX_BYTES = 55,
   parameter int CNT_W     = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [7:0]   byte_in,
   input  logic         byte_valid,
   input  logic         byte_last,
   output logic         byte_ready,
   output logic [447:0] m_out,
   output logic [15:0]  length,
   output logic         block_valid,
   input  logic         block_ready,
   output logic         overflow
);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      HOLD    = 2'd1,
      DROP    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_inc;
   logic             byte_xfer;
   logic             block_xfer;

   assign count_inc  = count + 1'b1;
   assign byte_ready = en & (state != HOLD);
   assign byte_xfer  = byte_ready & byte_valid;
   assign block_xfer = en & block_valid & block_ready;

   // m_out doubles as the assembly buffer; it is only meaningful to the
   // consumer while block_valid is high, and it is cleared between messages
   // so no bytes from a previous message can leak into the zero fill.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= COLLECT;
         count       <= '0;
         m_out       <= '0;
         length      <= '0;
         block_valid <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         // Overflow is a pulse: it only ever lives for the cycle after the
         // offending last byte, and with en low no byte can transfer.
         overflow <= 1'b0;
         case (state)
            COLLECT: begin
               if (byte_xfer) begin
                  if (count == MAX_CNT) begin
                     // This byte would be number MAX_BYTES+1: message too long.
                     if (byte_last) begin
                        overflow <= 1'b1;
                        m_out    <= '0;
                        count    <= '0;
                     end else begin
                        state <= DROP;
                     end
                  end else begin
                     for (int i = 0; i < 56; i++) begin
                        if (CNT_W'(i) == count)
                           m_out[447-8*i -: 8] <= byte_in;
                        // Marker goes right after the last data byte.
                        if (byte_last && (CNT_W'(i) == count_inc))
                           m_out[447-8*i -: 8] <= 8'h80;
                     end
                     count <= count_inc;
                     if (byte_last) begin
                        length      <= 16'(count_inc) << 3;
                        block_valid <= 1'b1;
                        state       <= HOLD;
                     end
                  end
               end
            end

            HOLD: begin
               if (block_xfer) begin
                  m_out       <= '0;
                  length      <= '0;
                  count       <= '0;
                  block_valid <= 1'b0;
                  state       <= COLLECT;
               end
            end

            DROP: begin
               // Remaining bytes of an over-long message are swallowed.
               if (byte_xfer && byte_last) begin
                  overflow <= 1'b1;
                  m_out    <= '0;
                  count    <= '0;
                  state    <= COLLECT;
               end
            end

            default: begin
               state <= COLLECT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md5_msg_packer.sv
module tb_md5_msg_packer;

   localparam int MAX_BYTES = 55;

   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic [7:0]   byte_in;
   logic         byte_valid;
   logic         byte_last;
   logic         byte_ready;
   logic [447:0] m_out;
   logic [15:0]  length;
   logic         block_valid;
   logic         block_ready;
   logic         overflow;

   md5_msg_packer #(.MAX_BYTES(MAX_BYTES), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .en(en),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last),
      .byte_ready(byte_ready), .m_out(m_out), .length(length),
      .block_valid(block_valid), .block_ready(block_ready), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference stream: bytes to send, their last/overflow tags, expected blocks.
   logic [7:0]   mbuf [64];
   logic [7:0]   tx_q [$];
   bit           last_q [$];
   bit           ovf_q [$];
   logic [447:0] exp_m_q [$];
   logic [15:0]  exp_len_q [$];
   logic [447:0] last_m;
   logic [15:0]  last_len;

   task automatic chk(input string tag, input logic [447:0] obs, input logic [447:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Padded field as a number: message bytes then 0x80, left-justified in 448 bits.
   function automatic logic [447:0] pad_model(input int n);
      logic [447:0] v;
      v = '0;
      for (int k = 0; k < n; k++) v = (v << 8) | 448'(mbuf[k]);
      v = (v << 8) | 448'(8'h80);
      return v << (8 * (55 - n));
   endfunction

   task automatic add_msg(input int n);
      for (int k = 0; k < n; k++) begin
         tx_q.push_back(mbuf[k]);
         last_q.push_back(k == n - 1);
         ovf_q.push_back((n > MAX_BYTES) && (k == n - 1));
      end
      if (n <= MAX_BYTES) begin
         exp_m_q.push_back(pad_model(n));
         exp_len_q.push_back(16'(n * 8));
      end
   endtask

   task automatic add_str(input string s);
      for (int k = 0; k < s.len(); k++) mbuf[k] = s[k];
      add_msg(s.len());
   endtask

   task automatic add_rand(input int n);
      for (int k = 0; k < n; k++) mbuf[k] = 8'($urandom);
      add_msg(n);
   endtask

   // Drives the queued stream and checks every cycle against the model state.
   task automatic stream(input int gap_pct, input int stall_pct, input int enoff_pct,
                         output int cycles);
      int idx;
      bit pend;
      bit ovfp;
      idx = 0; pend = 0; ovfp = 0; cycles = 0;
      while (idx < tx_q.size() || pend || ovfp) begin
         if (cycles >= 5000) begin
            vectors++;
            miscompares++;
            $error("FAIL stream_timeout observed=%0d expected=<5000", cycles);
            break;
         end
         @(negedge clk);
         cycles++;
         en          = ($urandom_range(0, 99) >= enoff_pct);
         block_ready = ($urandom_range(0, 99) >= stall_pct);
         if (idx < tx_q.size() && $urandom_range(0, 99) >= gap_pct) begin
            byte_valid = 1'b1;
            byte_in    = tx_q[idx];
            byte_last  = last_q[idx];
         end else begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            byte_last  = 1'($urandom);
         end
         #1;
         chk("block_valid", 448'(block_valid), 448'(pend));
         chk("byte_ready", 448'(byte_ready), 448'(en && !pend));
         chk("overflow", 448'(overflow), 448'(ovfp));
         if (pend) begin
            chk("m_out", m_out, exp_m_q[0]);
            chk("length", 448'(length), 448'(exp_len_q[0]));
         end
         ovfp = 0;
         if (en && pend && block_ready) begin
            last_m   = exp_m_q.pop_front();
            last_len = exp_len_q.pop_front();
            pend     = 0;
         end else if (en && !pend && byte_valid) begin
            if (last_q[idx]) begin
               if (ovf_q[idx]) ovfp = 1;
               else            pend = 1;
            end
            idx++;
         end
      end
      tx_q.delete(); last_q.delete(); ovf_q.delete();
      @(negedge clk);
      byte_valid  = 1'b0;
      block_ready = 1'b0;
      en          = 1'b1;
   endtask

   initial begin
      int cyc;
      reset = 1'b1; en = 1'b1; byte_in = '0; byte_valid = 1'b0;
      byte_last = 1'b0; block_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_m_out", m_out, '0);
      chk("rst_length", 448'(length), '0);
      chk("rst_block_valid", 448'(block_valid), '0);
      chk("rst_overflow", 448'(overflow), '0);
      chk("rst_byte_ready", 448'(byte_ready), 448'(1'b1));
      reset = 1'b0;

      // Single 19-byte message, downstream always ready.
      add_str("The quick brown fox");
      stream(0, 0, 0, cyc);
      chk("fox_head", 448'(last_m[447:288]),
          448'({152'h54686520_71756963_6b206272_6f776e20_666f78, 8'h80}));
      chk("fox_tail", 448'(last_m[287:0]), '0);
      chk("fox_len", 448'(last_len), 448'(16'h0098));

      // Back-to-back messages with no gaps: N+1 cycles each.
      add_str("Hello World 1234567");
      add_str("This is a test. 123");
      stream(0, 0, 0, cyc);
      chk("b2b_cycles", 448'(cyc), 448'(40));

      // One-byte message.
      mbuf[0] = 8'h61;
      add_msg(1);
      stream(0, 0, 0, cyc);
      chk("one_byte_field", last_m, {16'h6180, 432'h0});
      chk("one_byte_len", 448'(last_len), 448'(16'h0008));

      // Maximum length, one byte too many, far too many, then a short message.
      add_rand(55);
      stream(0, 0, 0, cyc);
      chk("max_marker", 448'(last_m[7:0]), 448'(8'h80));
      chk("max_len", 448'(last_len), 448'(16'h01B8));
      add_rand(56);
      add_rand(62);
      add_rand(3);
      stream(0, 0, 0, cyc);

      // Long downstream stalls and enable dropouts.
      add_str("The quick brown fox");
      add_rand(7);
      stream(10, 90, 0, cyc);
      add_rand(19);
      add_rand(40);
      stream(10, 20, 40, cyc);

      // Reset part-way through a message.
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         en = 1'b1; byte_valid = 1'b1; byte_last = 1'b0; byte_in = 8'($urandom);
      end
      @(negedge clk);
      byte_valid = 1'b0;
      reset      = 1'b1;
      @(negedge clk);
      chk("midrst_m_out", m_out, '0);
      chk("midrst_length", 448'(length), '0);
      chk("midrst_block_valid", 448'(block_valid), '0);
      chk("midrst_overflow", 448'(overflow), '0);
      reset = 1'b0;
      add_str("The quick brown fox");
      stream(0, 0, 0, cyc);
      chk("postrst_len", 448'(last_len), 448'(16'h0098));

      // Randomized mix of lengths, gaps, stalls and enable dropouts.
      for (int t = 0; t < 30; t++) add_rand($urandom_range(1, 60));
      stream(20, 30, 15, cyc);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
